// File: rtl/fir_channel_scheduler_if.sv
// ---------------------------------------------------------------------------
// fir_channel_scheduler_if
// Bundles the signals between the per-channel sample producers, the shared
// fir_filter, the output consumer and the scheduler.
//   req_valid / req_data / req_ready : per-channel sample stream (flat data,
//                                      channel i at [i*DATA_W +: DATA_W])
//   fir_data_in / fir_data_out       : registered sample to / result from filter
//   out_valid / out_chan / out_data  : tagged filter result
//   busy / grant_ch                  : scheduler status
// The scheduler side uses modport slave; producers/filter/consumer use master.
// ---------------------------------------------------------------------------
interface fir_channel_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH*DATA_W-1:0] req_data;
   logic [NUM_CH-1:0]        req_ready;
   logic [DATA_W-1:0]        fir_data_in;
   logic [DATA_W-1:0]        fir_data_out;
   logic                     out_valid;
   logic [CH_W-1:0]          out_chan;
   logic [DATA_W-1:0]        out_data;
   logic                     busy;
   logic [CH_W-1:0]          grant_ch;

   modport slave (
      input  req_valid, req_data, fir_data_out,
      output req_ready, fir_data_in, out_valid, out_chan, out_data, busy, grant_ch
   );

   modport master (
      output req_valid, req_data, fir_data_out,
      input  req_ready, fir_data_in, out_valid, out_chan, out_data, busy, grant_ch
   );
endinterface

// File: rtl/fir_channel_scheduler.sv
// ---------------------------------------------------------------------------
// fir_channel_scheduler
// Time-multiplexes one fir_filter between NUM_CH sample sources. A round-robin
// arbiter grants a channel for a burst of up to BURST_LEN samples, then
// FLUSH_LEN zero samples clear the filter history. A {valid, channel} tag
// pipeline, FIR_LAT stages behind the fir_data_in register, labels results.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : fir_channel_scheduler_if.slave (request streams, filter
//              in/out, tagged output, status)
// ---------------------------------------------------------------------------
module fir_channel_scheduler #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 16,
   parameter int FLUSH_LEN = 4,
   parameter int FIR_LAT   = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   fir_channel_scheduler_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BC_W = $clog2(BURST_LEN + 1);
   localparam int FC_W = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;

   typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_e;

   state_e                   state_q, state_d;
   logic [CH_W-1:0]          rr_q, rr_d;
   logic [CH_W-1:0]          grant_q, grant_d;
   logic [BC_W-1:0]          bcnt_q, bcnt_d, bcnt_inc;
   logic [FC_W-1:0]          fcnt_q, fcnt_d;
   logic [DATA_W-1:0]        fin_q, fin_d;
   logic                     tag_v_d;
   logic                     arb_hit;
   logic [CH_W-1:0]          arb_sel;
   // Stage 0 is written together with fir_data_in; stage FIR_LAT lines up
   // with the matching fir_data_out.
   logic [FIR_LAT:0]           vld_pipe_q;
   logic [FIR_LAT:0][CH_W-1:0] ch_pipe_q;

   // Round-robin pick: walk offsets from high to low so the smallest offset
   // from rr_q (first channel at or after the pointer) wins.
   always_comb begin
      arb_hit = 1'b0;
      arb_sel = rr_q;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (bus.req_valid[(int'(rr_q) + i) % NUM_CH]) begin
            arb_hit = 1'b1;
            arb_sel = CH_W'((int'(rr_q) + i) % NUM_CH);
         end
      end
   end

   assign bcnt_inc = bcnt_q + BC_W'(1);

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      bcnt_d  = bcnt_q;
      fcnt_d  = fcnt_q;
      fin_d   = '0;
      tag_v_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_hit) begin
               grant_d = arb_sel;
               bcnt_d  = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            if (bus.req_valid[grant_q]) begin
               fin_d   = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
               tag_v_d = 1'b1;
               bcnt_d  = bcnt_inc;
            end
            // A valid drop ends the burst; that cycle feeds a zero sample.
            if (!bus.req_valid[grant_q] || bcnt_inc == BC_W'(BURST_LEN)) begin
               rr_d    = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
               fcnt_d  = '0;
               state_d = (FLUSH_LEN == 0) ? IDLE : FLUSH;
            end
         end
         FLUSH: begin
            fcnt_d = fcnt_q + FC_W'(1);
            if (int'(fcnt_q) >= FLUSH_LEN - 1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rr_q       <= '0;
         grant_q    <= '0;
         bcnt_q     <= '0;
         fcnt_q     <= '0;
         fin_q      <= '0;
         vld_pipe_q <= '0;
         ch_pipe_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         bcnt_q     <= bcnt_d;
         fcnt_q     <= fcnt_d;
         fin_q      <= fin_d;
         vld_pipe_q <= {vld_pipe_q[FIR_LAT-1:0], tag_v_d};
         ch_pipe_q  <= {ch_pipe_q[FIR_LAT-1:0], grant_q};
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_rdy
      assign bus.req_ready[c] = (state_q == BURST) && (grant_q == CH_W'(c));
   end

   assign bus.fir_data_in = fin_q;
   assign bus.out_valid   = vld_pipe_q[FIR_LAT];
   assign bus.out_chan    = ch_pipe_q[FIR_LAT];
   assign bus.out_data    = bus.fir_data_out;
   assign bus.busy        = (state_q != IDLE);
   assign bus.grant_ch    = grant_q;
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fir_channel_scheduler
// Two scheduler instances: u_a (BURST_LEN=16, FLUSH_LEN=4) and u_b
// (BURST_LEN=1, FLUSH_LEN=0), both FIR_LAT=2, each with a pure-delay filter
// model. Channel c produces c*64 + (samples accepted so far) unless the
// constant-40 mode is on. Expected tagged outputs go into a queue per
// instance; monitors pop and compare on every out_valid.
// ---------------------------------------------------------------------------
module tb_fir_channel_scheduler;
   typedef struct packed {
      logic [1:0] ch;
      logic [7:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [3:0] v1, v2;
   logic const40;
   logic [3:0][7:0] cnt1, cnt2;
   logic [7:0] f1a, f1b, f2a, f2b;
   exp_t q1[$], q2[$];
   exp_t e1, e2;
   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int prev2 = -1;

   fir_channel_scheduler_if #(.NUM_CH(4), .DATA_W(8)) b1 ();
   fir_channel_scheduler_if #(.NUM_CH(4), .DATA_W(8)) b2 ();

   fir_channel_scheduler #(.NUM_CH(4), .DATA_W(8), .BURST_LEN(16), .FLUSH_LEN(4), .FIR_LAT(2))
      u_a (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
   fir_channel_scheduler #(.NUM_CH(4), .DATA_W(8), .BURST_LEN(1), .FLUSH_LEN(0), .FIR_LAT(2))
      u_b (.clk(clk), .reset_n(reset_n), .bus(b2.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pack(input logic [3:0][7:0] cnt, input logic k40);
      logic [31:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) r[c*8 +: 8] = k40 ? 8'd40 : (8'(c*64) + cnt[c]);
      return r;
   endfunction

   assign b1.req_valid    = v1;
   assign b2.req_valid    = v2;
   assign b1.req_data     = pack(cnt1, const40);
   assign b2.req_data     = pack(cnt2, 1'b0);
   assign b1.fir_data_out = f1b;
   assign b2.fir_data_out = f2b;

   // Producers advance on each accepted sample.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt1 <= '0;
         cnt2 <= '0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (b1.req_valid[c] && b1.req_ready[c]) cnt1[c] <= cnt1[c] + 8'd1;
            if (b2.req_valid[c] && b2.req_ready[c]) cnt2[c] <= cnt2[c] + 8'd1;
         end
      end
   end

   // Filter stand-in: 2-cycle pure delay so results equal the samples.
   always @(posedge clk) begin
      f1a <= b1.fir_data_in;
      f1b <= f1a;
      f2a <= b2.fir_data_in;
      f2b <= f2a;
   end

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic push1(input int ch, input int d);
      q1.push_back('{ch: 2'(ch), d: 8'(d)});
   endtask

   task automatic push2(input int ch, input int d);
      q2.push_back('{ch: 2'(ch), d: 8'(d)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Monitor for u_a
   always begin
      @(posedge clk);
      #1;
      if (b1.out_valid) begin
         n_cmp++;
         if (q1.size() == 0) begin
            n_bad++;
            $display("FAIL mon_a_unexpected: got ch=%0d data=%0d, required no output",
                     b1.out_chan, b1.out_data);
         end else begin
            e1 = q1.pop_front();
            if (b1.out_chan !== e1.ch || b1.out_data !== e1.d) begin
               n_bad++;
               $display("FAIL mon_a_out: got ch=%0d data=%0d, required ch=%0d data=%0d",
                        b1.out_chan, b1.out_data, e1.ch, e1.d);
            end
         end
      end
   end

   // Monitor for u_b, also checks the two-cycle spacing of results
   always begin
      @(posedge clk);
      #1;
      if (b2.out_valid) begin
         n_cmp++;
         if (q2.size() == 0) begin
            n_bad++;
            $display("FAIL mon_b_unexpected: got ch=%0d data=%0d, required no output",
                     b2.out_chan, b2.out_data);
         end else begin
            e2 = q2.pop_front();
            if (b2.out_chan !== e2.ch || b2.out_data !== e2.d) begin
               n_bad++;
               $display("FAIL mon_b_out: got ch=%0d data=%0d, required ch=%0d data=%0d",
                        b2.out_chan, b2.out_data, e2.ch, e2.d);
            end
         end
         if (prev2 >= 0) chk("mon_b_gap", cyc - prev2, 2);
         prev2 = cyc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int tfin, tov, nrdy, nov;
      v1 = '0;
      v2 = '0;
      const40 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", b1.busy, 0);
      chk("rst_ready", b1.req_ready, 0);
      chk("rst_outv", b1.out_valid, 0);
      chk("rst_outch", b1.out_chan, 0);
      chk("rst_fin", b1.fir_data_in, 0);
      chk("rst_grant", b1.grant_ch, 0);
      reset_n = 1'b1;

      // Idle with no requests
      repeat (20) begin
         @(negedge clk);
         chk("idle_quiet", int'({b1.busy, b1.req_ready, b1.fir_data_in, b1.out_valid}), 0);
      end

      // ch1 streams constant 40
      const40 = 1'b1;
      v1 = 4'b0010;
      for (int i = 0; i < 16; i++) push1(1, 40);
      tfin = -1; tov = -1; nrdy = 0; nov = 0;
      for (int k = 0; k < 26; k++) begin
         @(negedge clk);
         if (k == 16) v1 = '0;
         if (b1.req_ready[1]) nrdy++;
         if (b1.out_valid) nov++;
         if (b1.fir_data_in == 8'd40 && tfin < 0) tfin = k;
         if (b1.out_valid && tov < 0) tov = k;
         if (k == 0) chk("t2_grant", b1.grant_ch, 1);
         if (k == 19) chk("t2_flush_busy", b1.busy, 1);
         if (k == 20) chk("t2_flush_done", b1.busy, 0);
      end
      chk("t2_ready_cycles", nrdy, 16);
      chk("t2_out_cycles", nov, 16);
      chk("t2_latency", tov - tfin, 2);
      chk("t2_busy_end", b1.busy, 0);
      const40 = 1'b0;

      // ch0 and ch2 alternate
      do_reset();
      v1 = 4'b0101;
      for (int i = 0; i < 16; i++) push1(0, i);
      for (int i = 0; i < 16; i++) push1(2, 128 + i);
      for (int i = 0; i < 16; i++) push1(0, 16 + i);
      for (int i = 0; i < 16; i++) push1(2, 144 + i);
      for (int k = 0; k < 90; k++) begin
         @(negedge clk);
         if (k == 79) v1 = '0;
         chk("t3_ready_multihot", int'($countones(b1.req_ready) > 1), 0);
         if (k == 20) chk("t3_arb_gap", b1.busy, 0);
         if (k == 21) chk("t3_grant2", b1.grant_ch, 2);
         if (k == 42) chk("t3_grant0", b1.grant_ch, 0);
         if (k == 63) chk("t3_grant2b", b1.grant_ch, 2);
      end

      // ch3 drops valid after 5 transfers; pointer wraps to 0
      do_reset();
      v1 = 4'b1000;
      for (int i = 0; i < 5; i++) push1(3, 192 + i);
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         if (k == 5) v1 = '0;
         if (k == 6) begin
            chk("t4_drop_fin", b1.fir_data_in, 0);
            chk("t4_drop_ready", b1.req_ready, 0);
            chk("t4_drop_busy", b1.busy, 1);
         end
         if (k == 9) chk("t4_flush_busy", b1.busy, 1);
         if (k == 10) chk("t4_flush_done", b1.busy, 0);
         if (k == 11) v1 = 4'b1001;
         if (k == 12) begin
            chk("t4_rr_wrap", b1.grant_ch, 0);
            v1 = '0;
         end
      end

      // Reset mid-burst of ch1 (pointer is 1 beforehand)
      v1 = 4'b0010;
      push1(1, 64); push1(1, 65); push1(1, 66);
      for (int k = 0; k < 6; k++) @(negedge clk);
      reset_n = 1'b0;
      v1 = '0;
      #1;
      chk("t5_rst_outv", b1.out_valid, 0);
      chk("t5_rst_busy", b1.busy, 0);
      chk("t5_rst_fin", b1.fir_data_in, 0);
      repeat (3) begin
         @(negedge clk);
         chk("t5_hold_outv", b1.out_valid, 0);
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("t5_post_outv", b1.out_valid, 0);
      end
      chk("t5_post_busy", b1.busy, 0);
      v1 = 4'b0011;
      @(negedge clk);
      chk("t5_post_rr", b1.grant_ch, 0);
      v1 = '0;
      repeat (8) @(negedge clk);

      // BURST_LEN=1, FLUSH_LEN=0 rotation
      v2 = 4'hF;
      push2(0, 0); push2(1, 64); push2(2, 128); push2(3, 192); push2(0, 1); push2(1, 65);
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         if (k == 0) chk("t6_ready0", b2.req_ready, 1);
         if (k == 1) chk("t6_gap_idle", b2.busy, 0);
         if (k == 2) chk("t6_ready1", b2.req_ready, 2);
         if (k == 11) v2 = '0;
      end

      repeat (5) @(negedge clk);
      chk("a_queue_drained", q1.size(), 0);
      chk("b_queue_drained", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fir_channel_scheduler.md
Name: fir_channel_scheduler

Overview:
Time-multiplexes one shared fir_filter instance between NUM_CH sample sources. Round-robin arbitration grants one channel at a time for a burst of up to BURST_LEN samples, which are streamed into the filter. Each burst is followed by FLUSH_LEN zero samples that clear the filter history before the next channel is served. Outputs are tagged with the originating channel by a valid/channel pipeline matched to the filter latency. Sits between the per-channel sample producers and the fir_filter leaf.

Parameters:
NUM_CH, 4, number of requesting channels (>=2); CH_W = max(1, clog2(NUM_CH)) is derived.
DATA_W, 8, sample width; must match the fir_filter data width.
BURST_LEN, 16, maximum samples accepted per grant (>=1).
FLUSH_LEN, 4, zero samples inserted after each burst (>=0; 4 clears the 4-tap history).
FIR_LAT, 2, cycles from the fir_data_in register to the corresponding fir_data_out (>=1).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_CH  per-channel sample valid
req_data  input  NUM_CH*DATA_W  per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_CH  per-channel accept; at most one bit high
fir_data_in  output  DATA_W  registered sample driven to the filter
fir_data_out  input  DATA_W  filter result
out_valid  output  1  out_data carries a result belonging to out_chan
out_chan  output  CH_W  channel tag of the result
out_data  output  DATA_W  combinational pass-through of fir_data_out
busy  output  1  state != IDLE
grant_ch  output  CH_W  currently/last granted channel

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=0, grant_ch=0, burst/flush counters=0.
  - fir_data_in=0; every tag pipeline stage invalid.
  - out_valid=0, out_chan=0, busy=0, req_ready=0.
  - Reset asserted mid-burst or mid-flush aborts immediately; no out_valid is produced afterwards for samples already in flight.
- FSM states: IDLE, BURST, FLUSH.
- IDLE:
  - req_ready=0.
  - If any req_valid is high, select the first channel at or after rr_ptr, wrapping modulo NUM_CH, using that cycle's req_valid.
  - Latch the selection into grant_ch, clear the burst count, go to BURST. This costs one arbitration cycle.
- BURST:
  - req_ready[grant_ch]=1 (decoded combinationally from state and grant_ch); all other bits 0.
  - Transfer on req_valid[grant_ch] & req_ready: fir_data_in<=sample, tag_v<=1, tag_ch<=grant_ch, count++.
  - Burst ends after the transfer that makes count==BURST_LEN, or on the first cycle req_valid[grant_ch]=0. That non-transfer cycle drives fir_data_in<=0 with tag_v=0.
  - Bubbles never occur inside a burst; an early valid drop terminates the burst.
  - On burst end: rr_ptr<=(grant_ch+1) mod NUM_CH; go to FLUSH, or straight to IDLE if FLUSH_LEN==0.
  - Requests from other channels are ignored until the next IDLE.
- FLUSH:
  - req_ready=0.
  - Drive fir_data_in<=0, tag_v=0 for exactly FLUSH_LEN cycles (counting the cycles after the burst-end cycle), then go to IDLE.
- In IDLE and FLUSH, fir_data_in is 0 and tag_v is 0 every cycle.
- Tag pipeline:
  - FIR_LAT register stages carry {tag_v, tag_ch}, aligned to the fir_data_in register.
  - out_valid/out_chan are the final stage, so out_valid rises exactly FIR_LAT cycles after fir_data_in takes the sample.
  - No output backpressure: the filter cannot stall, so consumers must accept every out_valid cycle.
- No arithmetic on samples; counters are sized to hold BURST_LEN and FLUSH_LEN without wrapping.
- A channel whose req_valid is held high continuously never starves: it is granted within NUM_CH-1 bursts.

Test Plan:
- Reset, then req_valid=0 for 20 cycles -> busy=0, req_ready=0, fir_data_in=0, out_valid=0 throughout.
- ch1 streams a constant 40 continuously -> 1 idle cycle, then 16 transfers (req_ready[1]=1), then 4 zero cycles. out_valid with out_chan=1 for 16 cycles, starting 2 cycles after the first fir_data_in=40. The last outputs of the burst read 40 (with the fir_filter attached); busy returns to 0.
- ch0 and ch2 both held valid from reset -> grant order ch0, ch2, ch0, ch2. Each burst is 16 samples separated by 4 flush plus 1 arbitration cycles; req_ready is never multi-hot.
- ch3 drops req_valid after 5 transfers -> burst ends, exactly 5 out_valid tagged 3, a 4-cycle flush follows, rr_ptr wraps to 0.
- Assert reset_n=0 mid-burst with samples in the tag pipeline -> out_valid=0 immediately and stays 0; after release the FSM restarts in IDLE with rr_ptr=0.
- FLUSH_LEN=0, BURST_LEN=1 configuration with all channels valid -> one sample per grant, one-cycle gaps, channels rotate 0,1,2,3,0.
